// File: rtl/commit_rob.sv
// In-order commit stage: a small reorder buffer collects out-of-order branch results by commit ID
// and retires them one per cycle into the channel register file or the MAC accumulator.
module commit_rob #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_BRANCHES = 4,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ROB_DEPTH  = 8,
  parameter int unsigned N_CHANNELS = 16,
  localparam int unsigned CAW       = $clog2(N_CHANNELS),
  localparam int unsigned CNTW      = $clog2(ROB_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_enable,
  input  logic                             i_flush,
  input  logic                             i_sat_mode,
  input  logic                             i_sample_tick,
  input  logic [DATA_WIDTH-1:0]            i_sample_in,
  input  logic [N_BRANCHES-1:0]            i_in_valid,
  output logic [N_BRANCHES-1:0]            o_in_ready,
  input  logic [N_BRANCHES*ID_WIDTH-1:0]   i_in_id,
  input  logic [N_BRANCHES*2*DATA_WIDTH-1:0] i_in_result,
  input  logic [N_BRANCHES*CAW-1:0]        i_in_dest,
  input  logic [N_BRANCHES-1:0]            i_in_to_acc,
  input  logic [N_BRANCHES-1:0]            i_in_acc_overwrite,
  output logic [CAW-1:0]                   o_channel_write_addr,
  output logic [DATA_WIDTH-1:0]            o_channel_write_val,
  output logic                             o_channel_write_enable,
  output logic [2*DATA_WIDTH-1:0]          o_accumulator_write_val,
  output logic                             o_accumulator_write_enable,
  output logic                             o_accumulator_add_enable,
  output logic [ID_WIDTH-1:0]              o_next_commit_id,
  output logic [CNTW-1:0]                  o_rob_count
);

  localparam int unsigned SIW = $clog2(ROB_DEPTH);
  localparam int unsigned RW  = 2 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [ROB_DEPTH-1:0]  r_valid;
  logic [RW-1:0]         r_result [ROB_DEPTH];
  logic [CAW-1:0]        r_dest   [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]  r_to_acc;
  logic [ROB_DEPTH-1:0]  r_ovw;
  logic [ID_WIDTH-1:0]   r_head;
  logic [CNTW-1:0]       r_count;

  logic [CAW-1:0]        r_ch_addr;
  logic [DATA_WIDTH-1:0] r_ch_val;
  logic                  r_ch_we;
  logic [RW-1:0]         r_acc_val;
  logic                  r_acc_we;
  logic                  r_acc_add;

  logic [ID_WIDTH-1:0]   w_id   [N_BRANCHES];
  logic [SIW-1:0]        w_slot [N_BRANCHES];
  logic [ID_WIDTH-1:0]   w_dist [N_BRANCHES];
  logic [N_BRANCHES-1:0] w_ready;
  logic [CNTW-1:0]       w_n_acc;
  logic                  w_go;
  logic                  w_retire;
  logic [SIW-1:0]        w_head_slot;
  logic [RW-1:0]         w_head_res;
  logic [RW-DATA_WIDTH:0] w_upper;
  logic                  w_fits;
  logic [DATA_WIDTH-1:0] w_ch_val;

  assign w_go        = i_enable && !i_sample_tick && !i_flush && !reset;
  assign w_head_slot = r_head[SIW-1:0];
  assign w_retire    = i_enable && !i_sample_tick && !i_flush && r_valid[w_head_slot];

  always_comb begin
    for (int i = 0; i < N_BRANCHES; i++) begin
      w_id[i]   = i_in_id[i*ID_WIDTH +: ID_WIDTH];
      w_slot[i] = w_id[i][SIW-1:0];
      w_dist[i] = w_id[i] - r_head;
    end
  end

  // Within the window each slot maps to a single ID, so equal slots imply equal IDs.
  always_comb begin
    logic cand;
    w_ready = '0;
    for (int i = 0; i < N_BRANCHES; i++) begin
      cand = i_in_valid[i] && w_go && (32'(w_dist[i]) < ROB_DEPTH) && !r_valid[w_slot[i]];
      for (int j = 0; j < N_BRANCHES; j++) begin
        if (j < i && w_ready[j] && (w_slot[j] == w_slot[i])) cand = 1'b0;
      end
      w_ready[i] = cand;
    end
  end

  always_comb begin
    int n;
    n = 0;
    for (int i = 0; i < N_BRANCHES; i++) begin
      if (w_ready[i]) n = n + 1;
    end
    w_n_acc = CNTW'(n);
  end

  // Signed clamp: the value fits when every bit from the narrow sign bit upward agrees.
  assign w_head_res = r_result[w_head_slot];
  assign w_upper    = w_head_res[RW-1:DATA_WIDTH-1];
  assign w_fits     = (&w_upper) || !(|w_upper);

  always_comb begin
    w_ch_val = w_head_res[DATA_WIDTH-1:0];
    if (i_sat_mode && !w_fits) begin
      w_ch_val = w_head_res[RW-1] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= '0;
      r_to_acc  <= '0;
      r_ovw     <= '0;
      r_head    <= '0;
      r_count   <= '0;
      r_ch_addr <= '0;
      r_ch_val  <= '0;
      r_ch_we   <= 1'b0;
      r_acc_val <= '0;
      r_acc_we  <= 1'b0;
      r_acc_add <= 1'b0;
    end else begin
      r_ch_we  <= 1'b0;
      r_acc_we <= 1'b0;
      if (i_enable) begin
        if (i_flush) begin
          r_valid <= '0;
          r_head  <= '0;
          r_count <= '0;
        end else if (i_sample_tick) begin
          r_ch_addr <= '0;
          r_ch_val  <= i_sample_in;
          r_ch_we   <= 1'b1;
        end else begin
          for (int i = 0; i < N_BRANCHES; i++) begin
            if (w_ready[i]) begin
              r_valid[w_slot[i]]  <= 1'b1;
              r_result[w_slot[i]] <= i_in_result[i*RW +: RW];
              r_dest[w_slot[i]]   <= i_in_dest[i*CAW +: CAW];
              r_to_acc[w_slot[i]] <= i_in_to_acc[i];
              r_ovw[w_slot[i]]    <= i_in_acc_overwrite[i];
            end
          end
          // An accepted slot is never the valid head, so these writes do not collide.
          if (w_retire) begin
            r_valid[w_head_slot] <= 1'b0;
            r_head               <= r_head + 1'b1;
            if (r_to_acc[w_head_slot]) begin
              r_acc_val <= w_head_res;
              r_acc_we  <= 1'b1;
              r_acc_add <= !r_ovw[w_head_slot];
            end else begin
              r_ch_addr <= r_dest[w_head_slot];
              r_ch_val  <= w_ch_val;
              r_ch_we   <= 1'b1;
            end
          end
          r_count <= r_count + w_n_acc - CNTW'(w_retire);
        end
      end
    end
  end

  assign o_in_ready                 = w_ready;
  assign o_channel_write_addr       = r_ch_addr;
  assign o_channel_write_val        = r_ch_val;
  assign o_channel_write_enable     = r_ch_we;
  assign o_accumulator_write_val    = r_acc_val;
  assign o_accumulator_write_enable = r_acc_we;
  assign o_accumulator_add_enable   = r_acc_add;
  assign o_next_commit_id           = r_head;
  assign o_rob_count                = r_count;

endmodule

// File: tb/tb_commit_rob.sv
// Bench for commit_rob: a fixed vector table, a wrap-around sequence, then random traffic
// checked against an ID-keyed model of the reorder window.
module tb_commit_rob;

  localparam int NB = 4;

  logic         clk = 1'b0;
  logic         reset, en, flush, sat, tick;
  logic [15:0]  smp;
  logic [3:0]   vld, acc, ovw;
  logic [15:0]  ids, dst;
  logic [127:0] res;

  logic [3:0]  o_ready, o_caddr, o_head, o_cnt;
  logic [15:0] o_cval;
  logic        o_cwe, o_awe, o_aadd;
  logic [31:0] o_aval;

  commit_rob dut (
    .clk                        (clk),
    .reset                      (reset),
    .i_enable                   (en),
    .i_flush                    (flush),
    .i_sat_mode                 (sat),
    .i_sample_tick              (tick),
    .i_sample_in                (smp),
    .i_in_valid                 (vld),
    .o_in_ready                 (o_ready),
    .i_in_id                    (ids),
    .i_in_result                (res),
    .i_in_dest                  (dst),
    .i_in_to_acc                (acc),
    .i_in_acc_overwrite         (ovw),
    .o_channel_write_addr       (o_caddr),
    .o_channel_write_val        (o_cval),
    .o_channel_write_enable     (o_cwe),
    .o_accumulator_write_val    (o_aval),
    .o_accumulator_write_enable (o_awe),
    .o_accumulator_add_enable   (o_aadd),
    .o_next_commit_id           (o_head),
    .o_rob_count                (o_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model: pending results keyed by full commit ID.
  bit          m_pend [16];
  logic [31:0] m_res  [16];
  logic [3:0]  m_dst  [16];
  bit          m_acc  [16];
  bit          m_ovw  [16];
  int          m_head, m_cnt;
  logic [3:0]  e_caddr;
  logic [15:0] e_cval;
  logic [31:0] e_aval;
  bit          e_cwe, e_awe, e_aadd;
  logic [3:0]  m_rdy, r_seen;

  function automatic logic [15:0] clamp(input logic [31:0] r, input bit s);
    longint v;
    v = longint'($signed(r));
    if (!s) return r[15:0];
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return r[15:0];
  endfunction

  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    r = 4'b0;
    if (!(en && !tick && !flush && !reset)) return r;
    for (int i = 0; i < NB; i++) begin
      int id, d;
      bit busy;
      id   = int'(ids[i*4 +: 4]);
      d    = (id - m_head + 16) % 16;
      busy = 1'b0;
      for (int p = 0; p < 16; p++) if (m_pend[p] && (p % 8) == (id % 8)) busy = 1'b1;
      for (int j = 0; j < i; j++) if (r[j] && (int'(ids[j*4 +: 4]) % 8) == (id % 8)) busy = 1'b1;
      if (vld[i] && d < 8 && !busy) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_update();
    if (reset) begin
      for (int p = 0; p < 16; p++) m_pend[p] = 1'b0;
      m_head = 0; m_cnt = 0;
      e_caddr = '0; e_cval = '0; e_aval = '0; e_cwe = 0; e_awe = 0; e_aadd = 0;
    end else begin
      e_cwe = 0; e_awe = 0;
      if (en) begin
        if (flush) begin
          for (int p = 0; p < 16; p++) m_pend[p] = 1'b0;
          m_head = 0; m_cnt = 0;
        end else if (tick) begin
          e_caddr = 4'h0; e_cval = smp; e_cwe = 1;
        end else begin
          bit ret;
          int h;
          ret = m_pend[m_head];
          h   = m_head;
          for (int i = 0; i < NB; i++) begin
            if (m_rdy[i]) begin
              int id;
              id = int'(ids[i*4 +: 4]);
              m_pend[id] = 1'b1;
              m_res[id]  = res[i*32 +: 32];
              m_dst[id]  = dst[i*4 +: 4];
              m_acc[id]  = acc[i];
              m_ovw[id]  = ovw[i];
              m_cnt++;
            end
          end
          if (ret) begin
            m_pend[h] = 1'b0;
            m_cnt--;
            m_head = (m_head + 1) % 16;
            if (m_acc[h]) begin
              e_aval = m_res[h]; e_awe = 1; e_aadd = !m_ovw[h];
            end else begin
              e_caddr = m_dst[h]; e_cval = clamp(m_res[h], sat); e_cwe = 1;
            end
          end
        end
      end
    end
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    #1;
    m_rdy  = model_ready();
    r_seen = o_ready;
    chk("ready", 64'(o_ready), 64'(m_rdy));
    @(posedge clk);
    model_update();
    #1;
    chk("chwr", 64'({o_cwe, o_caddr, o_cval}), 64'({e_cwe, e_caddr, e_cval}));
    chk("accwr", 64'({o_awe, o_aadd, o_aval}), 64'({e_awe, e_aadd, e_aval}));
    chk("head", 64'(o_head), 64'(m_head[3:0]));
    chk("count", 64'(o_cnt), 64'(m_cnt[3:0]));
    @(negedge clk);
  endtask

  task automatic idle_in();
    vld = '0; ids = '0; res = '0; dst = '0; acc = '0; ovw = '0;
    tick = 0; flush = 0; smp = '0;
  endtask

  typedef struct {
    logic [3:0]   valid;
    logic [15:0]  ids;
    logic [127:0] res;
    logic [15:0]  dest;
    logic [3:0]   acc;
    logic [3:0]   ovw;
    logic         tick;
    logic         flush;
    logic         sat;
    logic [15:0]  smp;
    logic [3:0]   x_ready;
    logic         x_cwe;
    logic [3:0]   x_caddr;
    logic [15:0]  x_cval;
    logic         x_awe;
    logic         x_aadd;
    logic [3:0]   x_head;
    logic [3:0]   x_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0001, 16'h0000, {96'h0, 32'h0001_0010}, 16'h0003, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0,
                16'h0000, 4'b0001, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h1};
    tbl[1]  = '{4'b0001, 16'h0001, {96'h0, 32'h0001_0011}, 16'h0004, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0,
                16'h0000, 4'b0001, 1'b1, 4'h3, 16'h0010, 1'b0, 1'b0, 4'h1, 4'h1};
    tbl[2]  = '{4'b0001, 16'h0002, {96'h0, 32'h0001_0012}, 16'h0005, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0,
                16'h0000, 4'b0001, 1'b1, 4'h4, 16'h0011, 1'b0, 1'b0, 4'h2, 4'h1};
    tbl[3]  = '{4'b0000, 16'h0000, 128'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0,
                16'h0000, 4'b0000, 1'b1, 4'h5, 16'h0012, 1'b0, 1'b0, 4'h3, 4'h0};
    tbl[4]  = '{4'b0111, 16'h0345, {32'h0, 32'h3, 32'h4, 32'h5}, 16'h0345, 4'h0, 4'h0, 1'b0,
                1'b0, 1'b0, 16'h0000, 4'b0111, 1'b0, 4'h5, 16'h0012, 1'b0, 1'b0, 4'h3, 4'h3};
    tbl[5]  = '{4'b0000, 16'h0000, 128'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0,
                16'h0000, 4'b0000, 1'b1, 4'h3, 16'h0003, 1'b0, 1'b0, 4'h4, 4'h2};
    tbl[6]  = '{4'b1111, 16'h588C, {32'h2, 32'hDEAD_BEEF, 32'h0001_2345, 32'h1}, 16'h0080, 4'h0,
                4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0010, 1'b1, 4'h4, 16'h0004, 1'b0, 1'b0,
                4'h5, 4'h2};
    tbl[7]  = '{4'b0001, 16'h0006, {96'h0, 32'hFFFF_0000}, 16'h0006, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1,
                16'hABCD, 4'b0000, 1'b1, 4'h0, 16'hABCD, 1'b0, 1'b0, 4'h5, 4'h2};
    tbl[8]  = '{4'b0001, 16'h0006, {96'h0, 32'hFFFF_0000}, 16'h0006, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1,
                16'h0000, 4'b0001, 1'b1, 4'h5, 16'h0005, 1'b0, 1'b0, 4'h6, 4'h2};
    tbl[9]  = '{4'b0000, 16'h0000, 128'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1,
                16'h0000, 4'b0000, 1'b1, 4'h6, 16'h8000, 1'b0, 1'b0, 4'h7, 4'h1};
    tbl[10] = '{4'b0001, 16'h0007, {96'h0, 32'h1234_5678}, 16'h0000, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1,
                16'h0000, 4'b0001, 1'b0, 4'h6, 16'h8000, 1'b0, 1'b0, 4'h7, 4'h2};
    tbl[11] = '{4'b0000, 16'h0000, 128'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1,
                16'h0000, 4'b0000, 1'b0, 4'h6, 16'h8000, 1'b1, 1'b1, 4'h8, 4'h1};
    tbl[12] = '{4'b0000, 16'h0000, 128'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1,
                16'h0000, 4'b0000, 1'b1, 4'h8, 16'h7FFF, 1'b0, 1'b1, 4'h9, 4'h0};
    tbl[13] = '{4'b0001, 16'h0009, {96'h0, 32'h0001_2345}, 16'h0009, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0,
                16'h0000, 4'b0001, 1'b0, 4'h8, 16'h7FFF, 1'b0, 1'b1, 4'h9, 4'h1};
    tbl[14] = '{4'b0000, 16'h0000, 128'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0,
                16'h0000, 4'b0000, 1'b1, 4'h9, 16'h2345, 1'b0, 1'b1, 4'hA, 4'h0};
    tbl[15] = '{4'b0111, 16'h0DCB, {32'h0, 32'h13, 32'h12, 32'h11}, 16'h0123, 4'h0, 4'h0, 1'b0,
                1'b0, 1'b0, 16'h0000, 4'b0111, 1'b0, 4'h9, 16'h2345, 1'b0, 1'b1, 4'hA, 4'h3};
    tbl[16] = '{4'b0111, 16'h0DCB, {32'h0, 32'h13, 32'h12, 32'h11}, 16'h0123, 4'h0, 4'h0, 1'b1,
                1'b1, 1'b0, 16'h5555, 4'b0000, 1'b0, 4'h9, 16'h2345, 1'b0, 1'b1, 4'h0, 4'h0};
    tbl[17] = '{4'b0000, 16'h0000, 128'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0,
                16'h0000, 4'b0000, 1'b0, 4'h9, 16'h2345, 1'b0, 1'b1, 4'h0, 4'h0};

    idle_in();
    en = 1; sat = 0; reset = 1;
    @(negedge clk);
    step();
    step();
    chk("rst_head", 64'(o_head), 64'(0));
    chk("rst_count", 64'(o_cnt), 64'(0));
    chk("rst_we", 64'({o_cwe, o_awe, o_caddr, o_cval}), 64'(0));
    reset = 0;

    for (int k = 0; k < NV; k++) begin
      vld = tbl[k].valid; ids = tbl[k].ids; res = tbl[k].res; dst = tbl[k].dest;
      acc = tbl[k].acc; ovw = tbl[k].ovw; tick = tbl[k].tick; flush = tbl[k].flush;
      sat = tbl[k].sat; smp = tbl[k].smp;
      step();
      chk($sformatf("tbl%0d_ready", k), 64'(r_seen), 64'(tbl[k].x_ready));
      chk($sformatf("tbl%0d_chwr", k), 64'({o_cwe, o_caddr, o_cval}),
          64'({tbl[k].x_cwe, tbl[k].x_caddr, tbl[k].x_cval}));
      chk($sformatf("tbl%0d_acc", k), 64'({o_awe, o_aadd}), 64'({tbl[k].x_awe, tbl[k].x_aadd}));
      chk($sformatf("tbl%0d_head", k), 64'(o_head), 64'(tbl[k].x_head));
      chk($sformatf("tbl%0d_count", k), 64'(o_cnt), 64'(tbl[k].x_cnt));
    end

    // Wrap: walk the head to 14, then offer 14,15,0,1 out of order in one cycle.
    idle_in();
    for (int n = 0; n < 14; n++) begin
      vld = 4'b0001; ids = {12'h0, 4'(n)};
      res = {96'h0, $urandom}; dst = {12'h0, 4'($urandom)};
      acc = {3'b0, 1'($urandom)}; ovw = {3'b0, 1'($urandom)};
      step();
    end
    idle_in();
    step();
    step();
    chk("wrap_head14", 64'(o_head), 64'(14));
    vld = 4'b1111; ids = 16'hEF01;
    res = {$urandom, $urandom, $urandom, $urandom}; dst = 16'h4567;
    step();
    chk("wrap_ready", 64'(r_seen), 64'(4'b1111));
    idle_in();
    for (int n = 0; n < 5; n++) step();
    chk("wrap_head2", 64'(o_head), 64'(2));
    chk("wrap_count", 64'(o_cnt), 64'(0));

    // Random traffic against the model.
    reset = 1;
    step();
    reset = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 9) != 0);
      tick  = ($urandom_range(0, 19) == 0);
      flush = ($urandom_range(0, 49) == 0);
      sat   = 1'($urandom);
      smp   = 16'($urandom);
      for (int i = 0; i < NB; i++) begin
        logic [31:0] r;
        vld[i] = 1'($urandom);
        ids[i*4 +: 4] = 4'((m_head + int'($urandom_range(0, 9))) % 16);
        case ($urandom_range(0, 3))
          0: r = $urandom;
          1: r = {{16{1'($urandom)}}, 16'($urandom)};
          2: r = 32'h0000_8000;
          default: r = 32'hFFFF_7FFF;
        endcase
        res[i*32 +: 32] = r;
        dst[i*4 +: 4] = 4'($urandom);
        acc[i] = ($urandom_range(0, 3) == 0);
        ovw[i] = 1'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
